// File: rtl/branch_redirect_unit_pkg.sv
// Shared encodings for the EX-stage branch redirect logic: branch kinds,
// redirect FSM states and the delay-slot distance used in target arithmetic.
package branch_redirect_unit_pkg;

  localparam logic [1:0] BR_KIND_NONE = 2'b00;
  localparam logic [1:0] BR_KIND_COND = 2'b01;
  localparam logic [1:0] BR_KIND_J    = 2'b10;
  localparam logic [1:0] BR_KIND_JR   = 2'b11;

  typedef enum logic [1:0] {
    RDR_IDLE     = 2'b00,
    RDR_WAIT_DS  = 2'b01,
    RDR_REDIRECT = 2'b10
  } rdr_state_e;

  localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd4;

  // Branch immediates count words, so sign-extend and scale to bytes.
  function automatic logic [31:0] branch_byte_offset(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational selection between the PC-relative, J-format and register
// redirect targets; all arithmetic is 32-bit and wraps silently.
module branch_target_calc
  import branch_redirect_unit_pkg::*;
(
  input  logic [1:0]  br_kind,
  input  logic [31:0] pc,
  input  logic [15:0] offset,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_src,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + DELAY_SLOT_OFFSET;

  // Misaligned JR targets pass straight through; fetch reports the fault.
  always_comb begin
    case (br_kind)
      BR_KIND_COND: target = pc_plus4 + branch_byte_offset(offset);
      BR_KIND_J:    target = {pc_plus4[31:28], instr_index, 2'b00};
      BR_KIND_JR:   target = jr_src;
      default:      target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves EX-stage control transfers and holds the redirect back until the
// delay slot is fetched and IF accepts it; also counts taken transfers.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_valid,
  input  logic [1:0]       ex_br_kind,
  input  logic             ex_bresult,
  input  logic [31:0]      ex_pc,
  input  logic [15:0]      ex_offset,
  input  logic [25:0]      ex_instr_index,
  input  logic [31:0]      ex_jr_src,
  input  logic             ds_valid,
  input  logic             if_ready,
  input  logic             flush,
  output logic             ex_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] taken_cnt
);

  rdr_state_e  state;
  rdr_state_e  state_next;
  logic        res;
  logic        taken;
  logic        take;
  logic [31:0] target;

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("branch_redirect_unit: RESET_PC must be word aligned");
  end

  branch_target_calc u_target_calc (
    .br_kind     (ex_br_kind),
    .pc          (ex_pc),
    .offset      (ex_offset),
    .instr_index (ex_instr_index),
    .jr_src      (ex_jr_src),
    .target      (target)
  );

  // An unknown comparator result falls into the else branch: not taken.
  always_comb begin
    taken = 1'b1;
    if (ex_br_kind == BR_KIND_COND) begin
      if (ex_bresult) taken = 1'b1;
      else            taken = 1'b0;
    end
    res  = ex_valid && ex_ready && (ex_br_kind != BR_KIND_NONE) && !flush;
    take = res && taken;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RDR_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = RDR_IDLE;
    end else begin
      case (state)
        RDR_IDLE:     if (take) state_next = ds_valid ? RDR_REDIRECT : RDR_WAIT_DS;
        RDR_WAIT_DS:  if (ds_valid) state_next = RDR_REDIRECT;
        RDR_REDIRECT: if (if_ready) state_next = RDR_IDLE;
        default:      state_next = RDR_IDLE;
      endcase
    end
  end

  always_comb begin
    ex_ready       = (state == RDR_IDLE);
    redirect_valid = (state == RDR_REDIRECT);
  end

  // Target is captured only at resolve, so it stays put for the handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_pc <= 32'd0;
      taken_cnt   <= '0;
    end else if (take) begin
      redirect_pc <= target;
      taken_cnt   <= taken_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && res && (ex_br_kind == BR_KIND_COND))
      assert (!$isunknown(ex_bresult))
        else $error("branch_redirect_unit: unknown bresult on conditional branch");
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed and randomized checks of branch_redirect_unit against constants
// and a flag-based reference model of the redirect handshake.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ex_valid;
  logic [1:0]  ex_br_kind;
  logic        ex_bresult;
  logic [31:0] ex_pc;
  logic [15:0] ex_offset;
  logic [25:0] ex_instr_index;
  logic [31:0] ex_jr_src;
  logic        ds_valid;
  logic        if_ready;
  logic        flush;
  logic        ex_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] taken_cnt;

  int vectors = 0;
  int miscompares = 0;

  branch_redirect_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_valid       (ex_valid),
    .ex_br_kind     (ex_br_kind),
    .ex_bresult     (ex_bresult),
    .ex_pc          (ex_pc),
    .ex_offset      (ex_offset),
    .ex_instr_index (ex_instr_index),
    .ex_jr_src      (ex_jr_src),
    .ds_valid       (ds_valid),
    .if_ready       (if_ready),
    .flush          (flush),
    .ex_ready       (ex_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_br_kind = 2'b00; ex_bresult = 0; ex_pc = '0; ex_offset = '0;
    ex_instr_index = '0; ex_jr_src = '0; ds_valid = 0; if_ready = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 resetn = 1'b0;
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic drive_ctrl(input logic [1:0] kind, input logic [31:0] pc, input logic [15:0] off,
                            input logic [25:0] idx, input logic [31:0] jr, input logic bres);
    ex_valid = 1; ex_br_kind = kind; ex_pc = pc; ex_offset = off;
    ex_instr_index = idx; ex_jr_src = jr; ex_bresult = bres;
  endtask

  // Reference target: plain integer arithmetic on byte addresses.
  function automatic logic [31:0] ref_target(input logic [1:0] kind, input logic [31:0] pc,
                                             input logic [15:0] off, input logic [25:0] idx,
                                             input logic [31:0] jr);
    logic signed [15:0] soff;
    soff = off;
    case (kind)
      2'b01:   return pc + 32'd4 + 32'(int'(soff) * 4);
      2'b10:   return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
      default: return jr;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    #2 resetn = 1'b0;
    #1;
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b exp 0", redirect_valid); end
    vectors++; if (redirect_pc !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_pc got %h exp 0", redirect_pc); end
    vectors++; if (taken_cnt !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_cnt got %0d exp 0", taken_cnt); end
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b exp 1", ex_ready); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_beq();
    do_reset();
    drive_ctrl(2'b01, 32'h8000_0100, 16'h0004, '0, '0, 1'b1);
    ds_valid = 1; if_ready = 1;
    tick();
    ex_valid = 0;
    vectors++; if (redirect_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL beq_valid got %b exp 1", redirect_valid); end
    vectors++; if (redirect_pc !== 32'h8000_0114) begin miscompares++; $display("[TB] FAIL beq_pc got %h exp 80000114", redirect_pc); end
    vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_ready got %b exp 0", ex_ready); end
    tick();
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_drop got %b exp 0", redirect_valid); end
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL beq_idle got %b exp 1", ex_ready); end
    vectors++; if (taken_cnt !== 32'd1) begin miscompares++; $display("[TB] FAIL beq_cnt got %0d exp 1", taken_cnt); end
  endtask

  task automatic test_wait_ds();
    do_reset();
    drive_ctrl(2'b01, 32'h8000_0200, 16'hFFFF, '0, '0, 1'b1);
    ds_valid = 0; if_ready = 1;
    tick();
    ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wait_valid[%0d] got %b exp 0", i, redirect_valid); end
      vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wait_ready[%0d] got %b exp 0", i, ex_ready); end
      if (i < 2) tick();
    end
    ds_valid = 1; if_ready = 0;
    tick();
    vectors++; if (redirect_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_issue got %b exp 1", redirect_valid); end
    vectors++; if (redirect_pc !== 32'h8000_0200) begin miscompares++; $display("[TB] FAIL wait_pc got %h exp 80000200", redirect_pc); end
    if_ready = 1;
    tick();
    if_ready = 0; ds_valid = 0;
  endtask

  task automatic test_not_taken();
    do_reset();
    drive_ctrl(2'b01, 32'h8000_0300, 16'h0010, '0, '0, 1'b0);
    ds_valid = 1; if_ready = 1;
    tick();
    ex_valid = 0;
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL nt_valid got %b exp 0", redirect_valid); end
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL nt_ready got %b exp 1", ex_ready); end
    vectors++; if (taken_cnt !== 32'd0) begin miscompares++; $display("[TB] FAIL nt_cnt got %0d exp 0", taken_cnt); end
  endtask

  task automatic test_jump_hold();
    do_reset();
    drive_ctrl(2'b10, 32'h9FFF_FFFC, '0, 26'h0000040, '0, 1'b0);
    ds_valid = 1; if_ready = 0;
    tick();
    ex_valid = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (redirect_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_valid[%0d] got %b exp 1", i, redirect_valid); end
      vectors++; if (redirect_pc !== 32'hA000_0100) begin miscompares++; $display("[TB] FAIL j_pc[%0d] got %h exp a0000100", i, redirect_pc); end
      tick();
    end
    if_ready = 1;
    tick();
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_drop got %b exp 0", redirect_valid); end
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_idle got %b exp 1", ex_ready); end
    drive_ctrl(2'b11, 32'h8000_0000, '0, '0, 32'h8000_3000, 1'b0);
    if_ready = 0;
    tick();
    ex_valid = 0;
    vectors++; if (redirect_pc !== 32'h8000_3000) begin miscompares++; $display("[TB] FAIL jr_pc got %h exp 80003000", redirect_pc); end
    vectors++; if (taken_cnt !== 32'd2) begin miscompares++; $display("[TB] FAIL jr_cnt got %0d exp 2", taken_cnt); end
    if_ready = 1;
    tick();
    if_ready = 0;
  endtask

  task automatic test_flush();
    do_reset();
    drive_ctrl(2'b11, 32'h8000_0000, '0, '0, 32'h8000_4000, 1'b0);
    ds_valid = 0;
    tick();
    ex_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_wait_ready got %b exp 1", ex_ready); end
    ds_valid = 1; if_ready = 1;
    tick();
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_wait_valid got %b exp 0", redirect_valid); end
    drive_ctrl(2'b10, 32'h8000_0000, '0, 26'h1234, '0, 1'b0);
    flush = 1;
    tick();
    ex_valid = 0; flush = 0;
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_same_valid got %b exp 0", redirect_valid); end
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_same_ready got %b exp 1", ex_ready); end
    vectors++; if (taken_cnt !== 32'd1) begin miscompares++; $display("[TB] FAIL flush_same_cnt got %0d exp 1", taken_cnt); end
    ds_valid = 0; if_ready = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_ctrl(2'b01, 32'h8000_0500, 16'h0020, '0, '0, 1'b1);
    ds_valid = 1; if_ready = 0;
    tick();
    ex_valid = 0;
    vectors++; if (redirect_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_pre got %b exp 1", redirect_valid); end
    resetn = 1'b0;
    #1;
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_valid got %b exp 0", redirect_valid); end
    vectors++; if (taken_cnt !== 32'd0) begin miscompares++; $display("[TB] FAIL arst_cnt got %0d exp 0", taken_cnt); end
    vectors++; if (redirect_pc !== 32'd0) begin miscompares++; $display("[TB] FAIL arst_pc got %h exp 0", redirect_pc); end
    resetn = 1'b1;
    ds_valid = 0;
    tick();
  endtask

  // Model tracks "a redirect is owed" and "it is being offered to IF".
  task automatic test_random();
    bit          owed, offered;
    logic [31:0] m_pc, m_cnt;
    bit          tk;
    do_reset();
    owed = 0; offered = 0; m_pc = '0; m_cnt = '0;
    for (int c = 0; c < 500; c++) begin
      ex_valid       = ($urandom_range(0, 9) < 7);
      ex_br_kind     = 2'($urandom_range(0, 3));
      ex_bresult     = 1'($urandom_range(0, 1));
      ex_pc          = $urandom() & 32'hFFFF_FFFC;
      ex_offset      = 16'($urandom());
      ex_instr_index = 26'($urandom());
      ex_jr_src      = $urandom();
      ds_valid       = 1'($urandom_range(0, 1));
      if_ready       = 1'($urandom_range(0, 1));
      flush          = ($urandom_range(0, 15) == 0);
      if (flush) begin
        owed = 0; offered = 0;
      end else if (!owed) begin
        tk = ex_valid && (ex_br_kind != 2'b00) && (ex_br_kind != 2'b01 || ex_bresult);
        if (tk) begin
          m_pc = ref_target(ex_br_kind, ex_pc, ex_offset, ex_instr_index, ex_jr_src);
          m_cnt = m_cnt + 1;
          owed = 1;
          offered = ds_valid;
        end
      end else if (!offered) begin
        if (ds_valid) offered = 1;
      end else if (if_ready) begin
        owed = 0; offered = 0;
      end
      tick();
      vectors++; if (ex_ready !== !owed) begin miscompares++; $display("[TB] FAIL rnd_ready[%0d] got %b exp %b", c, ex_ready, !owed); end
      vectors++; if (redirect_valid !== offered) begin miscompares++; $display("[TB] FAIL rnd_valid[%0d] got %b exp %b", c, redirect_valid, offered); end
      vectors++; if (redirect_pc !== m_pc) begin miscompares++; $display("[TB] FAIL rnd_pc[%0d] got %h exp %h", c, redirect_pc, m_pc); end
      vectors++; if (taken_cnt !== m_cnt) begin miscompares++; $display("[TB] FAIL rnd_cnt[%0d] got %0d exp %0d", c, taken_cnt, m_cnt); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_beq();
    test_wait_ds();
    test_not_taken();
    test_jump_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
